// File: rtl/mac8_seq.sv
// mac8_seq: buffers a job of operand pairs, sequences them into the MAC, returns the sum.
// Ports: SYS_CLK/SYS_RST, start/len/busy job control, op_* in, mac_* to MAC, res_* out.
module mac8_seq #(
  parameter int DEPTH   = 4,
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 1
) (
  input  logic             SYS_CLK,
  input  logic             SYS_RST,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [7:0]       op_a,
  input  logic [7:0]       op_b,
  output logic             mac_clr,
  output logic             mac_en,
  output logic [7:0]       mac_a,
  output logic [7:0]       mac_b,
  input  logic [15:0]      mac_acc,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int DW = $clog2(MAC_LAT + 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  state_t           state_q;
  logic [LEN_W-1:0] tot_q;
  logic [LEN_W-1:0] acc_q;
  logic [LEN_W-1:0] iss_q;
  logic [LEN_W-1:0] iss_d;
  logic [DW-1:0]    drn_q;
  logic [PW-1:0]    wp_q;
  logic [PW-1:0]    rp_q;
  logic [15:0]      mem_q [DEPTH];
  logic             mac_clr_q;
  logic             mac_en_q;
  logic [7:0]       mac_a_q;
  logic [7:0]       mac_b_q;
  logic             res_valid_q;
  logic [15:0]      res_data_q;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic [15:0] head;

  // Extra MSB distinguishes full from empty when indices match.
  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[PW-1] != rp_q[PW-1]) &&
                 (wp_q[AW-1:0] == rp_q[AW-1:0]);

  assign op_ready = ((state_q == CLEAR) ||
                     (state_q == FEED)) &&
                    !full && (acc_q < tot_q);

  assign push  = op_valid && op_ready;
  assign pop   = (state_q == FEED) && !empty;
  assign head  = mem_q[rp_q[AW-1:0]];
  assign iss_d = iss_q + LEN_W'(1);

  always_ff @(posedge SYS_CLK) begin
    if (push) begin
      mem_q[wp_q[AW-1:0]] <= {op_a, op_b};
    end
  end

  always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
    if (!SYS_RST) begin
      state_q     <= IDLE;
      tot_q       <= '0;
      acc_q       <= '0;
      iss_q       <= '0;
      drn_q       <= '0;
      wp_q        <= '0;
      rp_q        <= '0;
      mac_clr_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      mac_clr_q <= 1'b0;
      mac_en_q  <= 1'b0;
      if (push) begin
        wp_q  <= wp_q + PW'(1);
        acc_q <= acc_q + LEN_W'(1);
      end
      unique case (state_q)
        IDLE: begin
          if (start) begin
            tot_q     <= len;
            acc_q     <= '0;
            iss_q     <= '0;
            mac_clr_q <= 1'b1;
            state_q   <= CLEAR;
          end
        end
        CLEAR: begin
          if (tot_q != '0) begin
            state_q <= FEED;
          end else begin
            drn_q   <= DW'(MAC_LAT);
            state_q <= DRAIN;
          end
        end
        FEED: begin
          if (pop) begin
            rp_q     <= rp_q + PW'(1);
            mac_a_q  <= head[15:8];
            mac_b_q  <= head[7:0];
            mac_en_q <= 1'b1;
            iss_q    <= iss_d;
            // Drain starts while the last strobe is still out.
            if (iss_d == tot_q) begin
              drn_q   <= DW'(MAC_LAT);
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drn_q == '0) begin
            res_data_q  <= mac_acc;
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            drn_q <= drn_q - DW'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign mac_clr   = mac_clr_q;
  assign mac_en    = mac_en_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_mac8_seq.sv
// tb_mac8_seq: directed jobs against a MAC model, scoreboard on issue and result ports.
// Stimulus pushes expected pairs/results; a negedge monitor pops and compares.
module tb_mac8_seq;

  logic        SYS_CLK;
  logic        SYS_RST;
  logic        start;
  logic [7:0]  len;
  logic        busy;
  logic        op_valid;
  logic        op_ready;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        mac_clr;
  logic        mac_en;
  logic [7:0]  mac_a;
  logic [7:0]  mac_b;
  logic [15:0] mac_acc;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;

  mac8_seq #(.DEPTH(4), .LEN_W(8), .MAC_LAT(1)) dut (
    .SYS_CLK(SYS_CLK),
    .SYS_RST(SYS_RST),
    .start(start),
    .len(len),
    .busy(busy),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .op_a(op_a),
    .op_b(op_b),
    .mac_clr(mac_clr),
    .mac_en(mac_en),
    .mac_a(mac_a),
    .mac_b(mac_b),
    .mac_acc(mac_acc),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data)
  );

  initial SYS_CLK = 1'b0;
  always #5 SYS_CLK = ~SYS_CLK;

  int checks = 0;
  int failures = 0;
  int cnt_en, cnt_clr, cnt_rdy, cnt_hs;
  int rv_cyc;
  bit seen;
  logic [15:0] en_hist;
  logic [15:0] res_q[$];
  logic [15:0] pr_q[$];
  logic [15:0] mon_p;
  logic [7:0]  pa[8];
  logic [7:0]  pb[8];

  // Registered MAC, one cycle of latency.
  logic [15:0] macc = 16'h0;
  always @(posedge SYS_CLK) begin
    if (mac_clr) macc <= 16'h0;
    else if (mac_en) macc <= macc + 16'(mac_a) * 16'(mac_b);
  end
  assign mac_acc = macc;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge SYS_CLK) begin
    if (mac_clr) cnt_clr++;
    if (op_ready) cnt_rdy++;
    if (op_valid && op_ready) cnt_hs++;
    if (mac_en) begin
      cnt_en++;
      if (pr_q.size() == 0) begin
        chk("unexpected_issue", 1, 0);
      end else begin
        mon_p = pr_q.pop_front();
        chk("issue_pair", {mac_a, mac_b}, mon_p);
      end
    end
    if (res_valid && res_ready) begin
      if (res_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        mon_p = res_q.pop_front();
        chk("res_data", res_data, mon_p);
      end
    end
  end

  task automatic drive(input int n, input int npat,
                       input logic [15:0] pat, input int abort);
    bit hs, v;
    int idx;
    idx = 0;
    seen = 0;
    en_hist = '0;
    rv_cyc = -1;
    for (int cyc = 0; cyc < 64; cyc++) begin
      if (cyc == abort) begin
        SYS_RST = 1'b0;
        #1;
        chk("reset_async",
            {busy, op_ready, mac_clr, mac_en, mac_a, mac_b,
             res_valid, res_data}, 0);
        op_valid = 1'b0;
        return;
      end
      v = (cyc >= npat) ? 1'b1 : pat[cyc[3:0]];
      op_valid = (idx < n) && v;
      op_a = pa[idx[2:0]];
      op_b = pb[idx[2:0]];
      @(negedge SYS_CLK);
      if (cyc < 16) en_hist[cyc] = mac_en;
      hs = op_valid && op_ready;
      if (res_valid && !seen) begin
        seen = 1;
        rv_cyc = cyc;
      end
      @(posedge SYS_CLK);
      #1;
      if (hs) idx++;
      if (seen) break;
    end
    if (!seen) chk("drive_timeout", 0, 1);
  endtask

  task automatic job(input int L, input int n, input int npat,
                     input logic [15:0] pat, input logic [15:0] exp_res,
                     input int exp_hs, input logic [15:0] exp_hist,
                     input int exp_rv, input int abort, input bit bp);
    int bad;
    cnt_en = 0;
    cnt_clr = 0;
    cnt_rdy = 0;
    cnt_hs = 0;
    res_ready = !bp;
    start = 1'b1;
    len = L[7:0];
    @(posedge SYS_CLK);
    #1;
    start = 1'b0;
    len = 8'hA5;
    if (abort < 0) res_q.push_back(exp_res);
    for (int i = 0; i < L && i < n; i++) pr_q.push_back({pa[i], pb[i]});
    drive(n, npat, pat, abort);
    if (abort >= 0) begin
      res_q.delete();
      pr_q.delete();
      repeat (2) @(posedge SYS_CLK);
      #1 SYS_RST = 1'b1;
      @(posedge SYS_CLK);
      #1;
      return;
    end
    if (bp) begin
      bad = 0;
      for (int i = 0; i < 10; i++) begin
        if (i == 3) begin
          start = 1'b1;
          len = 8'd5;
        end
        @(negedge SYS_CLK);
        if (!(res_valid && busy && res_data == exp_res)) bad++;
        @(posedge SYS_CLK);
        #1;
        start = 1'b0;
      end
      chk("bp_hold", bad, 0);
      res_ready = 1'b1;
      @(posedge SYS_CLK);
      #1;
    end
    @(negedge SYS_CLK);
    chk("idle_after", {busy, op_ready, res_valid}, 0);
    chk("mac_en_count", cnt_en, exp_hs);
    chk("mac_clr_count", cnt_clr, 1);
    chk("handshakes", cnt_hs, exp_hs);
    chk("en_timing", en_hist, exp_hist);
    chk("res_valid_cycle", rv_cyc, exp_rv);
    if (L == 0) chk("ready_zero_len", cnt_rdy, 0);
    chk("res_q_left", res_q.size(), 0);
    chk("pr_q_left", pr_q.size(), 0);
    op_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge SYS_CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    SYS_RST = 1'b0;
    start = 1'b0;
    len = 8'h0;
    op_valid = 1'b0;
    op_a = 8'h0;
    op_b = 8'h0;
    res_ready = 1'b1;
    repeat (2) @(negedge SYS_CLK);
    chk("reset_state",
        {busy, op_ready, mac_clr, mac_en, mac_a, mac_b,
         res_valid, res_data}, 0);
    @(posedge SYS_CLK);
    #1 SYS_RST = 1'b1;
    @(posedge SYS_CLK);
    #1;

    // Basic: 2*3 + 4*5 + 10*10 = 126
    pa = '{8'd2, 8'd4, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    pb = '{8'd3, 8'd5, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    job(3, 3, 0, 16'h0, 16'h007E, 3, 16'h001C, 6, -1, 0);

    // Zero length
    job(0, 0, 0, 16'h0, 16'h0000, 0, 16'h0000, 3, -1, 0);

    // Length limit: 1+4+9+16 = 30, 5th/6th pairs stall
    pa = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd0, 8'd0};
    pb = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd0, 8'd0};
    job(4, 6, 0, 16'h0, 16'h001E, 4, 16'h003C, 7, -1, 0);

    // Bubbles: valid 1,0,0,1,1,0,1; 21+72+30+300 = 423
    pa = '{8'd3, 8'd8, 8'd15, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0};
    pb = '{8'd7, 8'd9, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0};
    job(4, 4, 7, 16'h0059, 16'h01A7, 4, 16'h0164, 10, -1, 0);

    // Result backpressure: 7*6 + 5*4 = 62
    pa = '{8'd7, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    pb = '{8'd6, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    job(2, 2, 0, 16'h0, 16'h003E, 2, 16'h000C, 5, -1, 1);

    // Reset mid-FEED, then 255*255 = 0xFE01
    pa = '{8'd9, 8'd11, 8'd13, 8'd17, 8'd0, 8'd0, 8'd0, 8'd0};
    pb = '{8'd9, 8'd11, 8'd13, 8'd17, 8'd0, 8'd0, 8'd0, 8'd0};
    job(4, 4, 0, 16'h0, 16'h0000, 0, 16'h0000, 0, 4, 0);
    pa = '{8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    pb = '{8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    job(1, 1, 0, 16'h0, 16'hFE01, 1, 16'h0004, 4, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
